// File: rtl/l1match_queue_if.sv
// Bus bundle for l1match_queue: event inputs, readout controls and status/statistics outputs.
// DEPTH must match the DEPTH of the attached l1match_queue instance.
interface l1match_queue_if #(
   parameter int unsigned DEPTH = 8
);
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic          L1A;
   logic          MATCH;
   logic          MISS_MATCH;
   logic          NO_MATCH;
   logic          RD_EN;
   logic          CLR;
   logic [15:0]   DOUT;
   logic          EMPTY;
   logic          FULL;
   logic [CW-1:0] COUNT;
   logic          OVERFLOW;
   logic [15:0]   MATCH_CNT;
   logic [15:0]   MISS_CNT;
   logic [15:0]   NOMATCH_CNT;

   modport master (
      output L1A, MATCH, MISS_MATCH, NO_MATCH, RD_EN, CLR,
      input  DOUT, EMPTY, FULL, COUNT, OVERFLOW, MATCH_CNT, MISS_CNT, NOMATCH_CNT
   );

   modport slave (
      input  L1A, MATCH, MISS_MATCH, NO_MATCH, RD_EN, CLR,
      output DOUT, EMPTY, FULL, COUNT, OVERFLOW, MATCH_CNT, MISS_CNT, NOMATCH_CNT
   );
endinterface

// File: rtl/l1match_queue.sv
// L1A tag counter plus first-word-fall-through event FIFO for match/miss/no-match events.
// Define L1MATCH_STATS_EN to build the saturating per-type statistics counters.
module l1match_queue #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned TAG_W = 12
) (
   input logic           CLK,
   input logic           RST,
   l1match_queue_if.slave bus
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned EW = TAG_W + 2;

   logic [3:0]       in_now;
   logic [3:0]       hist_q;
   logic [3:0]       rise;
   logic [TAG_W-1:0] tag_q, tag_d;
   logic [EW-1:0]    mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             ovf_q, ovf_d;
   logic             empty, full;
   logic             pop, wr_req, wr_acc, drop;
   logic [1:0]       wr_type;
   logic [EW-1:0]    head;

   // Bit order {NO_MATCH, MISS_MATCH, MATCH, L1A}; history clears on reset so a level
   // already high right after release counts as a rising edge.
   assign in_now = {bus.NO_MATCH, bus.MISS_MATCH, bus.MATCH, bus.L1A};
   assign rise   = in_now & ~hist_q;

   assign empty  = (count_q == '0);
   assign full   = (count_q == CW'(DEPTH));
   assign wr_req = |rise[3:1];
   assign pop    = bus.RD_EN & ~empty;
   assign wr_acc = wr_req & (~full | pop);
   assign drop   = wr_req & full & ~pop;

   always_comb begin
      wr_type = 2'b11;
      if (rise[1]) begin
         wr_type = 2'b01;
      end else if (rise[2]) begin
         wr_type = 2'b10;
      end
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (wr_acc) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (wr_acc && !pop) begin
         count_d = count_q + CW'(1);
      end else if (pop && !wr_acc) begin
         count_d = count_q - CW'(1);
      end
      tag_d = tag_q + {{(TAG_W-1){1'b0}}, rise[0]};
      // A drop in the same cycle as CLR keeps the flag set.
      ovf_d = drop | (ovf_q & ~bus.CLR);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         hist_q   <= '0;
         tag_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         hist_q   <= in_now;
         tag_q    <= tag_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST && wr_acc) begin
         mem_q[wr_ptr_q] <= {wr_type, tag_q};
      end
   end

   assign head = mem_q[rd_ptr_q];

   always_comb begin
      bus.DOUT = '0;
      if (!empty) begin
         bus.DOUT[15:14]      = head[EW-1:EW-2];
         bus.DOUT[TAG_W-1:0]  = head[TAG_W-1:0];
      end
   end

   assign bus.EMPTY    = empty;
   assign bus.FULL     = full;
   assign bus.COUNT    = count_q;
   assign bus.OVERFLOW = ovf_q;

`ifdef L1MATCH_STATS_EN
   logic [15:0] match_cnt_q, miss_cnt_q, nomatch_cnt_q;

   // Counts every rising edge, queued or not; saturates at all-ones.
   always_ff @(posedge CLK) begin
      if (RST || bus.CLR) begin
         match_cnt_q   <= '0;
         miss_cnt_q    <= '0;
         nomatch_cnt_q <= '0;
      end else begin
         if (rise[1] && (match_cnt_q != 16'hFFFF)) begin
            match_cnt_q <= match_cnt_q + 16'd1;
         end
         if (rise[2] && (miss_cnt_q != 16'hFFFF)) begin
            miss_cnt_q <= miss_cnt_q + 16'd1;
         end
         if (rise[3] && (nomatch_cnt_q != 16'hFFFF)) begin
            nomatch_cnt_q <= nomatch_cnt_q + 16'd1;
         end
      end
   end

   assign bus.MATCH_CNT   = match_cnt_q;
   assign bus.MISS_CNT    = miss_cnt_q;
   assign bus.NOMATCH_CNT = nomatch_cnt_q;
`else
   assign bus.MATCH_CNT   = 16'h0000;
   assign bus.MISS_CNT    = 16'h0000;
   assign bus.NOMATCH_CNT = 16'h0000;
`endif
endmodule

// File: tb/tb_l1match_queue.sv
// Bench for l1match_queue: directed scenarios plus randomized traffic against a queue model.
module tb_l1match_queue;
   localparam int unsigned DEPTH = 8;
   localparam int unsigned TAG_W = 12;
`ifdef L1MATCH_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;

   l1match_queue_if #(.DEPTH(DEPTH)) bus ();

   l1match_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
      .CLK (clk),
      .RST (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: queue of 16-bit words, tag as an integer, per-type counts.
   logic [15:0] m_q [$];
   int          m_tag = 0;
   logic [3:0]  m_prev = 4'b0;
   bit          m_ovf = 1'b0;
   int          m_cnt [3] = '{0, 0, 0};

   task automatic model_step();
      bit el, em, emm, enm, pop, wr, full_b, drop;
      logic [1:0] ty;
      if (rst) begin
         m_q.delete();
         m_tag = 0;
         m_ovf = 1'b0;
         m_cnt = '{0, 0, 0};
         m_prev = 4'b0;
         return;
      end
      el  = bus.L1A        && !m_prev[0];
      em  = bus.MATCH      && !m_prev[1];
      emm = bus.MISS_MATCH && !m_prev[2];
      enm = bus.NO_MATCH   && !m_prev[3];
      pop    = bus.RD_EN && (m_q.size() != 0);
      full_b = (m_q.size() == DEPTH);
      wr     = em || emm || enm;
      ty     = em ? 2'b01 : (emm ? 2'b10 : 2'b11);
      drop   = wr && full_b && !pop;
      if (pop) void'(m_q.pop_front());
      if (wr && !drop) m_q.push_back({ty, 2'b00, 12'(m_tag)});
      if (bus.CLR) m_ovf = 1'b0;
      if (drop) m_ovf = 1'b1;
      if (bus.CLR) begin
         m_cnt = '{0, 0, 0};
      end else begin
         if (em  && m_cnt[0] < 65535) m_cnt[0]++;
         if (emm && m_cnt[1] < 65535) m_cnt[1]++;
         if (enm && m_cnt[2] < 65535) m_cnt[2]++;
      end
      m_tag  = (m_tag + int'(el)) % 4096;
      m_prev = {bus.NO_MATCH, bus.MISS_MATCH, bus.MATCH, bus.L1A};
   endtask

   function automatic logic [15:0] exp_cnt(input int i);
      return STATS ? 16'(m_cnt[i]) : 16'h0000;
   endfunction

   function automatic logic [6:0] status();
      return {bus.EMPTY, bus.FULL, bus.COUNT, bus.OVERFLOW};
   endfunction

   task automatic drive(input bit l1a, m, mm, nm, rd, clr);
      bus.L1A = l1a; bus.MATCH = m; bus.MISS_MATCH = mm; bus.NO_MATCH = nm;
      bus.RD_EN = rd; bus.CLR = clr;
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      drive(0, 0, 0, 0, 0, 0);
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      drive(1, 1, 1, 1, 1, 1);
      rst = 1'b1;
      tick();
      tick();
      n_checks++;
      if (status() !== 7'b1_0_0000_0)
         begin n_fail++; $display("FAIL reset_status: got %b expected %b", status(), 7'b1000000); end
      n_checks++;
      if (bus.DOUT !== 16'h0000)
         begin n_fail++; $display("FAIL reset_dout: got %h expected 0000", bus.DOUT); end
      n_checks++;
      if ({bus.MATCH_CNT, bus.MISS_CNT, bus.NOMATCH_CNT} !== 48'h0)
         begin n_fail++; $display("FAIL reset_counters: got %h expected 0",
                                  {bus.MATCH_CNT, bus.MISS_CNT, bus.NOMATCH_CNT}); end
      drive(0, 0, 0, 0, 0, 0);
      rst = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         drive(1, 0, 0, 0, 0, 0); tick();
         drive(0, 0, 0, 0, 0, 0); tick();
      end
      n_checks++;
      if (bus.EMPTY !== 1'b1)
         begin n_fail++; $display("FAIL basic_pre_empty: got %b expected 1", bus.EMPTY); end
      drive(0, 1, 0, 0, 0, 0); tick();
      n_checks++;
      if ({bus.DOUT, status()} !== {16'h4003, 7'b0_0_0001_0})
         begin n_fail++; $display("FAIL basic_first: got %h/%b expected 4003/%b",
                                  bus.DOUT, status(), 7'b0000010); end
      // Held MATCH must not produce more entries.
      tick(); tick();
      n_checks++;
      if (bus.COUNT !== 4'd1)
         begin n_fail++; $display("FAIL basic_held_level: got %0d expected 1", bus.COUNT); end
      drive(0, 0, 0, 0, 1, 0); tick();
      n_checks++;
      if ({bus.DOUT, status()} !== {16'h0000, 7'b1_0_0000_0})
         begin n_fail++; $display("FAIL basic_pop: got %h/%b expected 0000/%b",
                                  bus.DOUT, status(), 7'b1000000); end
      tick(); tick();
      drive(0, 0, 0, 0, 0, 0); tick();
      drive(0, 0, 1, 0, 0, 0); tick();
      n_checks++;
      if ({bus.DOUT, status()} !== {16'h8003, 7'b0_0_0001_0})
         begin n_fail++; $display("FAIL basic_empty_read_ignored: got %h/%b expected 8003/%b",
                                  bus.DOUT, status(), 7'b0000010); end
   endtask

   task automatic test_simultaneous();
      do_reset();
      for (int i = 0; i < 5; i++) begin
         drive(1, 0, 0, 0, 0, 0); tick();
         drive(0, 0, 0, 0, 0, 0); tick();
      end
      drive(0, 1, 0, 1, 0, 0); tick();
      n_checks++;
      if ({bus.DOUT, bus.COUNT} !== {16'h4005, 4'd1})
         begin n_fail++; $display("FAIL simul_entry: got %h/%0d expected 4005/1",
                                  bus.DOUT, bus.COUNT); end
      n_checks++;
      if ({bus.MATCH_CNT, bus.NOMATCH_CNT} !== {(STATS ? 16'd1 : 16'd0), (STATS ? 16'd1 : 16'd0)})
         begin n_fail++; $display("FAIL simul_counters: got %0d/%0d expected %0d/%0d",
                                  bus.MATCH_CNT, bus.NOMATCH_CNT, STATS, STATS); end
      drive(0, 0, 0, 0, 0, 0); tick();
   endtask

   task automatic test_overflow();
      do_reset();
      for (int i = 0; i < 9; i++) begin
         drive(1, 0, 1, 0, 0, 0); tick();
         drive(0, 0, 0, 0, 0, 0); tick();
      end
      n_checks++;
      if (status() !== 7'b0_1_1000_1)
         begin n_fail++; $display("FAIL ovf_status: got %b expected %b", status(), 7'b0110001); end
      n_checks++;
      if (bus.MISS_CNT !== (STATS ? 16'd9 : 16'd0))
         begin n_fail++; $display("FAIL ovf_miss_cnt: got %0d expected %0d",
                                  bus.MISS_CNT, STATS ? 9 : 0); end
      drive(0, 0, 0, 0, 0, 1); tick();
      n_checks++;
      if (status() !== 7'b0_1_1000_0)
         begin n_fail++; $display("FAIL ovf_clr: got %b expected %b", status(), 7'b0110000); end
      // Drop and CLR in the same cycle: flag stays set.
      drive(0, 0, 1, 0, 0, 1); tick();
      n_checks++;
      if (bus.OVERFLOW !== 1'b1)
         begin n_fail++; $display("FAIL ovf_clr_vs_drop: got %b expected 1", bus.OVERFLOW); end
      drive(0, 0, 0, 0, 0, 1); tick();
      drive(0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 8; i++) begin
         n_checks++;
         if (bus.DOUT !== (16'h8000 | 16'(i)))
            begin n_fail++; $display("FAIL ovf_readout[%0d]: got %h expected %h",
                                     i, bus.DOUT, 16'h8000 | 16'(i)); end
         drive(0, 0, 0, 0, 1, 0); tick();
      end
      drive(0, 0, 0, 0, 0, 0);
      n_checks++;
      if ({bus.DOUT, status()} !== {16'h0000, 7'b1_0_0000_0})
         begin n_fail++; $display("FAIL ovf_drained: got %h/%b expected 0000/%b",
                                  bus.DOUT, status(), 7'b1000000); end
   endtask

   task automatic test_full_rw();
      do_reset();
      for (int i = 0; i < 8; i++) begin
         drive(1, 1, 0, 0, 0, 0); tick();
         drive(0, 0, 0, 0, 0, 0); tick();
      end
      drive(0, 1, 0, 0, 1, 0); tick();
      n_checks++;
      if (status() !== 7'b0_1_1000_0)
         begin n_fail++; $display("FAIL fullrw_status: got %b expected %b", status(), 7'b0110000); end
      drive(0, 0, 0, 0, 0, 0);
      for (int i = 1; i <= 8; i++) begin
         n_checks++;
         if (bus.DOUT !== (16'h4000 | 16'(i)))
            begin n_fail++; $display("FAIL fullrw_readout[%0d]: got %h expected %h",
                                     i, bus.DOUT, 16'h4000 | 16'(i)); end
         drive(0, 0, 0, 0, 1, 0); tick();
      end
      drive(0, 0, 0, 0, 0, 0);
   endtask

   task automatic test_tag_wrap();
      do_reset();
      for (int i = 0; i < 4096; i++) begin
         drive(1, 0, 0, 0, 0, 0); tick();
         drive(0, 0, 0, 0, 0, 0); tick();
      end
      drive(0, 0, 0, 1, 0, 0); tick();
      n_checks++;
      if ({bus.DOUT, bus.COUNT} !== {16'hC000, 4'd1})
         begin n_fail++; $display("FAIL tag_wrap: got %h/%0d expected c000/1", bus.DOUT, bus.COUNT); end
      drive(0, 0, 0, 0, 0, 0); tick();
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int i = 0; i < 4; i++) begin
         drive(0, 1, 0, 0, 0, 0); tick();
         drive(0, 0, 0, 0, 0, 0); tick();
      end
      drive(0, 1, 0, 0, 1, 1);
      rst = 1'b1;
      tick();
      n_checks++;
      if ({bus.DOUT, status()} !== {16'h0000, 7'b1_0_0000_0})
         begin n_fail++; $display("FAIL midrst_flush: got %h/%b expected 0000/%b",
                                  bus.DOUT, status(), 7'b1000000); end
      rst = 1'b0;
      drive(0, 1, 0, 0, 0, 0); tick();
      n_checks++;
      if ({bus.DOUT, bus.COUNT} !== {16'h4000, 4'd1})
         begin n_fail++; $display("FAIL midrst_release_event: got %h/%0d expected 4000/1",
                                  bus.DOUT, bus.COUNT); end
      drive(0, 0, 0, 0, 0, 0); tick();
   endtask

   task automatic test_random();
      logic [15:0] exp_dout;
      logic [6:0]  exp_st;
      do_reset();
      for (int c = 0; c < 1500; c++) begin
         int rd_div;
         rd_div = (c < 700) ? 8 : 2;
         drive($urandom_range(0, 1) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
               $urandom_range(0, 3) == 0, $urandom_range(0, rd_div - 1) == 0,
               $urandom_range(0, 24) == 0);
         rst = ($urandom_range(0, 199) == 0);
         tick();
         exp_dout = (m_q.size() != 0) ? m_q[0] : 16'h0000;
         exp_st   = {m_q.size() == 0, m_q.size() == DEPTH, 4'(m_q.size()), m_ovf};
         n_checks++;
         if ({bus.DOUT, status(), bus.MATCH_CNT, bus.MISS_CNT, bus.NOMATCH_CNT} !==
             {exp_dout, exp_st, exp_cnt(0), exp_cnt(1), exp_cnt(2)})
            begin n_fail++;
               $display("FAIL random[%0d]: got dout=%h st=%b cnt=%0d/%0d/%0d expected dout=%h st=%b cnt=%0d/%0d/%0d",
                        c, bus.DOUT, status(), bus.MATCH_CNT, bus.MISS_CNT, bus.NOMATCH_CNT,
                        exp_dout, exp_st, exp_cnt(0), exp_cnt(1), exp_cnt(2));
            end
      end
      rst = 1'b0;
      drive(0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      drive(0, 0, 0, 0, 0, 0);
      test_reset();
      test_basic();
      test_simultaneous();
      test_overflow();
      test_full_rw();
      test_tag_wrap();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
